// File: rtl/edge_window_pkg.sv
// Shared widths, cross-block field layout and packing helper for the edge window stage.
package edge_window_pkg;

   localparam int unsigned PIX_W     = 8;
   localparam int unsigned BLOCK_W   = 32;
   localparam int unsigned UP_LSB    = 24;
   localparam int unsigned RIGHT_LSB = 16;
   localparam int unsigned DOWN_LSB  = 8;
   localparam int unsigned LEFT_LSB  = 0;

   typedef struct packed {
      logic [PIX_W-1:0] up;
      logic [PIX_W-1:0] right;
      logic [PIX_W-1:0] down;
      logic [PIX_W-1:0] left;
   } cross_t;

   // Place each neighbour at its field offset in the kernel's block_in word.
   function automatic logic [BLOCK_W-1:0] pack_cross(input cross_t c);
      logic [BLOCK_W-1:0] v;
      v = '0;
      v[UP_LSB    +: PIX_W] = c.up;
      v[RIGHT_LSB +: PIX_W] = c.right;
      v[DOWN_LSB  +: PIX_W] = c.down;
      v[LEFT_LSB  +: PIX_W] = c.left;
      return v;
   endfunction

endpackage

// File: rtl/edge_cross_window_line_ram.sv
// Single line of pixel storage: one write port, one asynchronous read port.
// A same-address read in the write cycle returns the old contents.
module line_ram #(
   parameter  int unsigned DEPTH = 640,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata_c
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/edge_cross_window.sv
// Raster pixel stream to {up,right,down,left} cross blocks for interior pixels.
// Optional EDGE_CROSS_WINDOW_SOF_CHECK_EN adds a sticky sof_err flag.
module edge_cross_window
   import edge_window_pkg::*;
#(
   parameter  int unsigned LINE_WIDTH   = 640,
   parameter  int unsigned FRAME_HEIGHT = 480,
   localparam int unsigned XW           = $clog2(LINE_WIDTH),
   localparam int unsigned YW           = $clog2(FRAME_HEIGHT)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [PIX_W-1:0]   in_pixel,
   input  logic               in_sof,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [BLOCK_W-1:0] out_block,
   output logic [XW-1:0]      out_x,
   output logic [YW-1:0]      out_y,
   output logic               out_valid,
   input  logic               out_ready
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
   ,
   output logic               sof_err
`endif
);

   logic               r_out_valid;
   logic [BLOCK_W-1:0] r_out_block;
   logic [XW-1:0]      r_out_x;
   logic [YW-1:0]      r_out_y;
   logic [XW-1:0]      r_col;
   logic [YW-1:0]      r_row;
   logic [PIX_W-1:0]   r_p1;
   logic [PIX_W-1:0]   r_a1;
   logic [PIX_W-1:0]   r_a2;
   logic [PIX_W-1:0]   r_b1;

   logic               w_accept;
   logic               w_emit;
   logic [XW-1:0]      w_col;
   logic [YW-1:0]      w_row;
   logic               w_col_last;
   logic               w_row_last;
   logic [PIX_W-1:0]   w_b1_rd;
   logic [PIX_W-1:0]   w_b2_rd;
   cross_t             w_cross;

   assign in_ready = ~r_out_valid | out_ready;
   assign w_accept = in_valid & in_ready;

   // Position of the pixel currently offered; a start-of-frame forces (0,0).
   assign w_col      = in_sof ? '0 : r_col;
   assign w_row      = in_sof ? '0 : r_row;
   assign w_col_last = (w_col == XW'(LINE_WIDTH - 1));
   assign w_row_last = (w_row == YW'(FRAME_HEIGHT - 1));
   assign w_emit     = w_accept & (w_row >= YW'(2)) & (w_col >= XW'(2));

   // B1 holds the previous line, B2 the one before; B1's old word shifts into B2.
   line_ram #(
      .DEPTH (LINE_WIDTH),
      .WIDTH (PIX_W)
   ) u_line_b1 (
      .clk       (clock),
      .i_we      (w_accept),
      .i_waddr   (w_col),
      .i_wdata   (in_pixel),
      .i_raddr   (w_col),
      .o_rdata_c (w_b1_rd)
   );

   line_ram #(
      .DEPTH (LINE_WIDTH),
      .WIDTH (PIX_W)
   ) u_line_b2 (
      .clk       (clock),
      .i_we      (w_accept),
      .i_waddr   (w_col),
      .i_wdata   (w_b1_rd),
      .i_raddr   (w_col),
      .o_rdata_c (w_b2_rd)
   );

   always_comb begin
      w_cross       = '0;
      w_cross.up    = r_b1;
      w_cross.right = w_b1_rd;
      w_cross.down  = r_p1;
      w_cross.left  = r_a2;
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : w_row + YW'(1);
         end else begin
            r_col <= w_col + XW'(1);
            r_row <= w_row;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_p1 <= '0;
         r_a1 <= '0;
         r_a2 <= '0;
         r_b1 <= '0;
      end else if (w_accept) begin
         r_p1 <= in_pixel;
         r_a1 <= w_b1_rd;
         r_a2 <= r_a1;
         r_b1 <= w_b2_rd;
      end
   end

   // Output register: an accept always frees or replaces it, otherwise drains on ready.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_block <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
      end else if (w_accept) begin
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_out_block <= pack_cross(w_cross);
            r_out_x     <= w_col - XW'(1);
            r_out_y     <= w_row - YW'(1);
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_block = r_out_block;
   assign out_x     = r_out_x;
   assign out_y     = r_out_y;

`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
   logic r_sof_err;
   logic r_frame_done;
   logic w_at_origin;

   assign w_at_origin = (r_col == '0) && (r_row == '0);

   // Sticky framing error: misplaced SOF, or a new frame started without one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sof_err    <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (w_accept) begin
         if (in_sof && !w_at_origin) begin
            r_sof_err <= 1'b1;
         end
         if (!in_sof && w_at_origin && r_frame_done) begin
            r_sof_err <= 1'b1;
         end
         if (w_col_last && w_row_last) begin
            r_frame_done <= 1'b1;
         end
      end
   end

   assign sof_err = r_sof_err;
`endif

endmodule

// File: tb/tb_edge_cross_window.sv
// Self-checking bench for edge_cross_window: directed frames plus random stalls
// against an image-array reference model.
`timescale 1ns/1ps
module tb_edge_cross_window;

   localparam int unsigned LW = 4;
   localparam int unsigned FH = 4;
   localparam int unsigned XW = $clog2(LW);
   localparam int unsigned YW = $clog2(FH);

   logic          clock;
   logic          reset_n;
   logic [7:0]    in_pixel;
   logic          in_sof;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   out_block;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_valid;
   logic          out_ready;
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
   logic          sof_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0]  img [FH][LW];
   int          mc, mr;
   logic        m_valid;
   logic [31:0] m_block;
   int          m_x, m_y;
   logic        m_err, m_done;
   logic [31:0] got [$];

   logic [31:0] exp_frame [4] = '{32'h01122110, 32'h02132211, 32'h11223120, 32'h12233221};

   edge_cross_window #(
      .LINE_WIDTH   (LW),
      .FRAME_HEIGHT (FH)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_pixel  (in_pixel),
      .in_sof    (in_sof),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_block (out_block),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
      ,
      .sof_err   (sof_err)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h required 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mc      = 0;
      mr      = 0;
      m_valid = 1'b0;
      m_block = '0;
      m_x     = 0;
      m_y     = 0;
      m_err   = 1'b0;
      m_done  = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs visible now.
   task automatic model_step();
      int  c, r, pos;
      logic acc;
      acc = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) got.push_back(out_block);
      if (acc) begin
         c = in_sof ? 0 : mc;
         r = in_sof ? 0 : mr;
         if (in_sof && (mc != 0 || mr != 0)) m_err = 1'b1;
         if (!in_sof && mc == 0 && mr == 0 && m_done) m_err = 1'b1;
         img[r][c] = in_pixel;
         if (r >= 2 && c >= 2) begin
            m_valid = 1'b1;
            m_block = {img[r-2][c-1], img[r-1][c], img[r][c-1], img[r-1][c-2]};
            m_x     = c - 1;
            m_y     = r - 1;
         end else begin
            m_valid = 1'b0;
         end
         if (c == int'(LW) - 1 && r == int'(FH) - 1) m_done = 1'b1;
         pos = r * int'(LW) + c + 1;
         if (pos == int'(LW * FH)) pos = 0;
         mc = pos % int'(LW);
         mr = pos / int'(LW);
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Compare DUT against the model on every falling edge, then advance the model.
   always @(negedge clock) begin
      if (!reset_n) begin
         model_reset();
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_block", out_block, 32'd0);
         check("rst_out_xy", 32'({out_x, out_y}), 32'd0);
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
         check("rst_sof_err", 32'(sof_err), 32'd0);
`endif
      end else begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         if (m_valid) begin
            check("out_block", out_block, m_block);
            check("out_x", 32'(out_x), 32'(m_x));
            check("out_y", 32'(out_y), 32'(m_y));
         end
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
         check("sof_err", 32'(sof_err), 32'(m_err));
`endif
         model_step();
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_px(input logic [7:0] pix, input logic sof);
      logic acc;
      int   n;
      in_pixel = pix;
      in_sof   = sof;
      in_valid = 1'b1;
      acc      = 1'b0;
      n        = 0;
      while (!acc && n < 200) begin
         @(negedge clock);
         acc = in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_first(input int npix, input logic [7:0] add);
      for (int i = 0; i < npix; i++) begin
         send_px(8'(16 * (i / int'(LW)) + (i % int'(LW))) + add, i == 0);
      end
   endtask

   task automatic check_frame(input string tag, input int base);
      check({tag, "_count"}, 32'(got.size()), 32'(base + 4));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_blk%0d", tag, i), got[base + i], exp_frame[i]);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      in_pixel  = '0;
      in_sof    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(3);
      reset_n = 1'b1;
      idle(2);

      // Plain frame, downstream always ready
      got.delete();
      send_first(int'(LW * FH), 8'h00);
      idle(5);
      check_frame("plain", 0);

      // First block stalled for five cycles
      got.delete();
      out_ready = 1'b0;
      fork
         send_first(int'(LW * FH), 8'h00);
         begin : stall_thread
            int n;
            n = 0;
            do begin
               @(negedge clock);
               n++;
            end while (!out_valid && n < 200);
            if (!out_valid) check("stall_wait", 32'd0, 32'd1);
            for (int k = 0; k < 5; k++) begin
               check("stall_hold_block", out_block, 32'h01122110);
               check("stall_in_ready", 32'(in_ready), 32'd0);
               if (k < 4) @(negedge clock);
            end
            @(posedge clock);
            #1;
            out_ready = 1'b1;
         end
      join
      idle(5);
      check_frame("stall", 0);

      // Two back-to-back frames, second offset by 0x40
      got.delete();
      send_first(int'(LW * FH), 8'h00);
      send_first(int'(LW * FH), 8'h40);
      idle(5);
      check("b2b_count", 32'(got.size()), 32'd8);
      check("b2b_f2_first", got[4], 32'h41526150);
      check("b2b_f2_last", got[7], 32'h52637261);

      // Reset in the middle of a frame, then a fresh frame
      send_first(9, 8'h00);
      reset_n = 1'b0;
      @(negedge clock);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      idle(2);
      reset_n = 1'b1;
      idle(2);
      got.delete();
      send_first(int'(LW * FH), 8'h00);
      idle(5);
      check_frame("after_rst", 0);
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
      check("sof_err_clean", 32'(sof_err), 32'd0);
`endif

      // Start of frame arriving at (2,1)
      got.delete();
      send_first(6, 8'h00);
      send_first(int'(LW * FH), 8'h00);
      idle(5);
      check_frame("mid_sof", 0);
`ifdef EDGE_CROSS_WINDOW_SOF_CHECK_EN
      check("sof_err_set", 32'(sof_err), 32'd1);
      idle(5);
      check("sof_err_sticky", 32'(sof_err), 32'd1);
`endif

      // Random valid/ready/sof traffic, checked cycle by cycle by the model
      got.delete();
      repeat (4000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_pixel  = 8'($urandom);
         in_sof    = ($urandom_range(0, 31) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clock);
         #1;
      end
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b1;
      idle(5);
      check("rand_blocks_seen", 32'(got.size() > 100), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/edge_cross_window.md
Name: edge_cross_window

Overview:
- Streaming upstream stage for the thresholded edge kernel.
- Accepts one 8-bit grayscale pixel per handshake, in raster order.
- Buffers the two previous lines internally and emits, for every interior pixel, the 32-bit cross neighbourhood {up,right,down,left} that the edge kernel consumes as block_in, with valid/ready flow control.

Parameters:
LINE_WIDTH, 640, pixels per line (>=3)
FRAME_HEIGHT, 480, lines per frame (>=3)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_pixel  in  8  grayscale pixel
in_sof  in  1  marks first pixel of frame; qualified by in_valid
in_valid  in  1  pixel valid
in_ready  out  1  stage can accept a pixel
out_block  out  32  {up[31:24], right[23:16], down[15:8], left[7:0]}
out_x  out  clog2(LINE_WIDTH)  centre column, 1..LINE_WIDTH-2
out_y  out  clog2(FRAME_HEIGHT)  centre row, 1..FRAME_HEIGHT-2
out_valid  out  1  block valid
out_ready  in  1  downstream accepts block

Behaviour:
- Reset is asynchronous and active-low on reset_n, clocked by clock. Async assert, sync release is external.
- Reset values: out_valid=0, out_block=0, out_x=0, out_y=0, col=0, row=0, delay registers=0. Line memory contents are don't-care.
- in_ready = !out_valid | out_ready. A pixel is accepted when in_valid & in_ready.
- Counters col/row hold the position of the next accepted pixel.
  - On accept with in_sof=1, the pixel is treated as (0,0).
  - col wraps at LINE_WIDTH-1 and increments row.
  - row wraps at FRAME_HEIGHT-1 to 0.
  - Counters are unchanged when no pixel is accepted.
- Line buffers: B1 holds row r-1, B2 holds row r-2, each LINE_WIDTH x 8. On accepting pixel (c,r):
  - read B1[c] and B2[c];
  - write B2[c] <= B1[c] and B1[c] <= in_pixel in the same cycle (read-before-write).
- Delay taps, advanced only on accept:
  - p1 = previous in_pixel
  - a1, a2 = B1 reads at c-1, c-2
  - b1 = B2 read at c-1
- Emission: on accepting (c,r) with r>=2 and c>=2, emit centre (c-1,r-1) one cycle later:
  - up = b1
  - right = B1[c]
  - down = p1
  - left = a2
  - out_x = c-1, out_y = r-1
  - Taps must not span line boundaries; the c>=2 gate guarantees this.
- Latency: out_valid is asserted on the clock edge following the accept.
- Output hold: while out_valid & !out_ready, out_block, out_x and out_y are held stable and in_ready=0.
- Output count: exactly (LINE_WIDTH-2)*(FRAME_HEIGHT-2) blocks per frame. There is no border output and no flush.
- Simultaneous events: out_ready and an accept in the same cycle replace the output with no bubble. Throughput is 1 pixel/cycle.
- in_sof mid-frame: counters restart at (0,0); stale line data is never emitted because r<2.
- Reset mid-frame: all state cleared; the next frame must begin with in_sof or is counted from (0,0).

Optional Feature:
- Macro: EDGE_CROSS_WINDOW_SOF_CHECK_EN.
- Enabled: adds output port sof_err (1 bit, reset 0), a sticky flag.
  - Set when in_sof is accepted while (col,row) != (0,0).
  - Set when a pixel without in_sof is accepted at (0,0) after the first frame.
  - Cleared only by reset_n.
- Disabled: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package edge_window_pkg:
  - PIX_W=8
  - field offsets UP_LSB=24, RIGHT_LSB=16, DOWN_LSB=8, LEFT_LSB=0
  - BLOCK_W=32
- Sub-module line_ram: parameterised depth/width, one read port, one write port, same-address read-before-write, no reset. Instantiate twice (B1, B2).

Test Plan:
- Use LINE_WIDTH=4, FRAME_HEIGHT=4, pixel=16*r+c, out_ready=1, continuous in_valid. Send the frame starting with in_sof -> exactly 4 blocks:
  - (1,1)=0x01122110
  - (2,1)=0x02132211
  - (1,2)=0x11223120
  - (2,2)=0x12233221
  - each block arrives 1 cycle after pixels (2,2),(3,2),(2,3),(3,3) respectively.
- Same frame, out_ready held low 5 cycles at the first block -> out_block stays 0x01122110, in_ready=0, no pixel lost; final sequence identical.
- Two back-to-back frames, the second with pixel+0x40 -> the second frame's first block is 0x41526150, with no contamination from frame 1.
- Assert reset_n low at pixel (1,2) of frame 1, release, then send a fresh frame -> out_valid=0 during reset, first output 0x01122110.
- SOF_CHECK_EN defined: in_sof at pixel (2,1) -> sof_err=1 and stays 1; output resumes per the new frame.
- SOF_CHECK_EN not defined: the same stimulus gives no error and the same output.
- Random in_valid/out_ready stall pattern, 640x480 default -> 638*478 blocks, each matching a reference model.
